priority_decoder: RTL and testbench

PRIORITY_DECODER -- requirements
Module: prioritydecoder

---
 rtl/priority_decoder_if.sv | 33 +++
 rtl/priority_decoder.sv | 99 +++++++++
 tb/tb_priority_decoder.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/priority_decoder_if.sv
// rtl/priority_decoder_if.sv - request/result bus bundle for priority_decoder
//
// Groups the request handshake (idx_i, op_i, in_valid_i, in_ready_o, flush_i)
// and the result handshake (onehot_o, mask_o, count_o, empty_o, out_valid_o,
// out_ready_i). Signal suffixes are from the decoder's point of view.
// slave modport: the decoder. master modport: the requester/consumer.
interface priority_decoder_if #(
    parameter int SIZE = 5
);
    localparam int N = 1 << SIZE;

    logic [SIZE-1:0] idx_i;
    logic [1:0]      op_i;
    logic            in_valid_i;
    logic            in_ready_o;
    logic            flush_i;
    logic [N-1:0]    onehot_o;
    logic [N-1:0]    mask_o;
    logic [SIZE:0]   count_o;
    logic            empty_o;
    logic            out_valid_o;
    logic            out_ready_i;

    modport slave (
        input  idx_i, op_i, in_valid_i, flush_i, out_ready_i,
        output in_ready_o, onehot_o, mask_o, count_o, empty_o, out_valid_o
    );

    modport master (
        output idx_i, op_i, in_valid_i, flush_i, out_ready_i,
        input  in_ready_o, onehot_o, mask_o, count_o, empty_o, out_valid_o
    );
endinterface

// File: rtl/priority_decoder.sv
// rtl/priority_decoder.sv - index decoder with mask register and one-entry output stage
//
// Ports:
//   clk_i   - clock, all state changes on the rising edge
//   rst_n_i - asynchronous active-low reset
//   bus     - priority_decoder_if slave modport:
//             idx_i/op_i/in_valid_i/in_ready_o : request (LOAD/SET/CLR/TOGGLE)
//             flush_i                          : synchronous clear of the mask
//             onehot_o/mask_o/count_o/empty_o  : registered result
//             out_valid_o/out_ready_i          : result handshake
module priority_decoder #(
    parameter int SIZE = 5
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    priority_decoder_if.slave   bus
);
    localparam int N = 1 << SIZE;

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_SET    = 2'b01;
    localparam logic [1:0] OP_CLR    = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    onehot_q, onehot_d;
    logic [N-1:0]    mask_q, mask_d;
    logic [SIZE:0]   count_q, count_d;
    logic            empty_q, empty_d;

    logic            in_ready;
    logic            accept;
    logic [N-1:0]    dec;
    logic [N-1:0]    base;

    // Consumer draining the slot this cycle frees it for a new request.
    assign in_ready = (state_q == ST_EMPTY) || bus.out_ready_i;
    assign accept   = bus.in_valid_i && in_ready;
    assign dec      = {{(N-1){1'b0}}, 1'b1} << bus.idx_i;
    // Flush is applied before the op, so an accepted op sees a zero mask.
    assign base     = bus.flush_i ? '0 : mask_q;

    always_comb begin
        state_d  = state_q;
        onehot_d = onehot_q;
        mask_d   = base;
        count_d  = '0;

        if (accept) begin
            onehot_d = dec;
            case (bus.op_i)
                OP_LOAD:   mask_d = dec;
                OP_SET:    mask_d = base | dec;
                OP_CLR:    mask_d = base & ~dec;
                OP_TOGGLE: mask_d = base ^ dec;
                default:   mask_d = base;
            endcase
        end

        for (int i = 0; i < N; i++) begin
            count_d = count_d + {{SIZE{1'b0}}, mask_d[i]};
        end
        empty_d = (mask_d == '0);

        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL;
            ST_FULL:  if (!accept && bus.out_ready_i) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_EMPTY;
            onehot_q <= '0;
            mask_q   <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            onehot_q <= onehot_d;
            mask_q   <= mask_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = (state_q == ST_FULL);
    assign bus.onehot_o    = onehot_q;
    assign bus.mask_o      = mask_q;
    assign bus.count_o     = count_q;
    assign bus.empty_o     = empty_q;
endmodule

// File: tb/tb_priority_decoder.sv
// tb/tb_priority_decoder.sv - self-checking bench for priority_decoder
module tb_priority_decoder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    priority_decoder_if #(.SIZE(5)) bus ();
    priority_decoder #(.SIZE(5)) dut (.clk_i(clk), .rst_n_i(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;

    // reference model: what the consumer should observe
    logic        m_valid;
    logic [31:0] m_onehot;
    logic [31:0] m_mask;
    logic        exp_ready;
    logic        obs_ready;

    function automatic int popcount(input logic [31:0] v);
        int c = 0;
        for (int i = 0; i < 32; i++) if (v[i]) c++;
        return c;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_onehot = '0; m_mask = '0;
    endtask

    // Present one cycle of stimulus, advance the model, step past the edge.
    task automatic drive(input logic v, input logic [4:0] idx, input logic [1:0] op,
                         input logic fl, input logic ordy);
        logic [31:0] d, b;
        logic acc;
        bus.in_valid_i = v; bus.idx_i = idx; bus.op_i = op;
        bus.flush_i = fl; bus.out_ready_i = ordy;
        #1;
        obs_ready = bus.in_ready_o;
        exp_ready = !m_valid || ordy;
        acc = v && exp_ready;
        d = 32'd1 << idx;
        b = fl ? 32'd0 : m_mask;
        if (acc) begin
            m_onehot = d;
            m_valid  = 1'b1;
            case (op)
                2'd0: m_mask = d;
                2'd1: m_mask = b | d;
                2'd2: m_mask = b & ~d;
                default: m_mask = b ^ d;
            endcase
        end else begin
            m_mask = b;
            if (m_valid && ordy) m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        bus.in_valid_i = 1'b0; bus.flush_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid_o); end
        checks++; if (bus.onehot_o !== 32'd0) begin errors++; $display("FAIL reset_onehot: got %h expected 0", bus.onehot_o); end
        checks++; if (bus.mask_o !== 32'd0) begin errors++; $display("FAIL reset_mask: got %h expected 0", bus.mask_o); end
        checks++; if (bus.count_o !== 6'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.count_o); end
        checks++; if (bus.empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", bus.empty_o); end
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready_i = 1'b0;
        #1;
        checks++; if (bus.in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.in_ready_o); end
    endtask

    task automatic test_load_msb();
        drive(1'b1, 5'd31, 2'd0, 1'b0, 1'b1);
        checks++; if (bus.out_valid_o !== 1'b1) begin errors++; $display("FAIL load_valid: got %b expected 1", bus.out_valid_o); end
        checks++; if (bus.onehot_o !== 32'h8000_0000) begin errors++; $display("FAIL load_onehot: got %h expected 80000000", bus.onehot_o); end
        checks++; if (bus.mask_o !== 32'h8000_0000) begin errors++; $display("FAIL load_mask: got %h expected 80000000", bus.mask_o); end
        checks++; if (bus.count_o !== 6'd1) begin errors++; $display("FAIL load_count: got %0d expected 1", bus.count_o); end
        checks++; if (bus.empty_o !== 1'b0) begin errors++; $display("FAIL load_empty: got %b expected 0", bus.empty_o); end
    endtask

    task automatic test_back_to_back();
        logic [4:0] idxs [3] = '{5'd0, 5'd5, 5'd31};
        drive(1'b0, 5'd0, 2'd0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, idxs[i], 2'd1, 1'b0, 1'b1);
            checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b expected 1", i, obs_ready); end
            checks++; if (bus.out_valid_o !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b expected 1", i, bus.out_valid_o); end
        end
        checks++; if (bus.mask_o !== 32'h8000_0021) begin errors++; $display("FAIL b2b_mask: got %h expected 80000021", bus.mask_o); end
        checks++; if (bus.count_o !== 6'd3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", bus.count_o); end
    endtask

    task automatic test_stall();
        drive(1'b1, 5'd2, 2'd0, 1'b0, 1'b1);
        drive(1'b1, 5'd9, 2'd1, 1'b0, 1'b0);
        checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b expected 0", obs_ready); end
        checks++; if (bus.mask_o !== 32'h4) begin errors++; $display("FAIL stall_mask: got %h expected 4", bus.mask_o); end
        checks++; if (bus.onehot_o !== 32'h4) begin errors++; $display("FAIL stall_onehot: got %h expected 4", bus.onehot_o); end
        checks++; if (bus.out_valid_o !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b expected 1", bus.out_valid_o); end
        drive(1'b1, 5'd9, 2'd1, 1'b0, 1'b1);
        checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b expected 1", obs_ready); end
        checks++; if (bus.mask_o !== 32'h204) begin errors++; $display("FAIL release_mask: got %h expected 204", bus.mask_o); end
        checks++; if (bus.out_valid_o !== 1'b1) begin errors++; $display("FAIL release_valid: got %b expected 1", bus.out_valid_o); end
        drive(1'b0, 5'd0, 2'd0, 1'b0, 1'b1);
        checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b expected 0", bus.out_valid_o); end
    endtask

    task automatic test_clr_toggle();
        logic [31:0] exp_m [3] = '{32'h0, 32'h10, 32'h0};
        logic [1:0]  ops   [3] = '{2'd2, 2'd3, 2'd3};
        drive(1'b1, 5'd4, 2'd0, 1'b0, 1'b1);
        checks++; if (bus.mask_o !== 32'h10) begin errors++; $display("FAIL ct_load: got %h expected 10", bus.mask_o); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd4, ops[i], 1'b0, 1'b1);
            checks++; if (bus.mask_o !== exp_m[i]) begin errors++; $display("FAIL ct_mask[%0d]: got %h expected %h", i, bus.mask_o, exp_m[i]); end
            checks++; if (bus.empty_o !== (exp_m[i] == 0)) begin errors++; $display("FAIL ct_empty[%0d]: got %b expected %b", i, bus.empty_o, exp_m[i] == 0); end
            checks++; if (bus.count_o !== 6'(popcount(exp_m[i]))) begin errors++; $display("FAIL ct_count[%0d]: got %0d expected %0d", i, bus.count_o, popcount(exp_m[i])); end
        end
    endtask

    task automatic test_full_flush();
        for (int i = 0; i < 32; i++) drive(1'b1, 5'(i), 2'd1, 1'b0, 1'b1);
        checks++; if (bus.mask_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL full_mask: got %h expected ffffffff", bus.mask_o); end
        checks++; if (bus.count_o !== 6'd32) begin errors++; $display("FAIL full_count: got %0d expected 32", bus.count_o); end
        drive(1'b1, 5'd7, 2'd1, 1'b1, 1'b1);
        checks++; if (bus.mask_o !== 32'h80) begin errors++; $display("FAIL flushset_mask: got %h expected 80", bus.mask_o); end
        checks++; if (bus.count_o !== 6'd1) begin errors++; $display("FAIL flushset_count: got %0d expected 1", bus.count_o); end
        // flush alone while FULL and stalled
        drive(1'b0, 5'd0, 2'd0, 1'b1, 1'b0);
        checks++; if (bus.mask_o !== 32'h0) begin errors++; $display("FAIL flush_mask: got %h expected 0", bus.mask_o); end
        checks++; if (bus.empty_o !== 1'b1) begin errors++; $display("FAIL flush_empty: got %b expected 1", bus.empty_o); end
        checks++; if (bus.out_valid_o !== 1'b1) begin errors++; $display("FAIL flush_valid: got %b expected 1", bus.out_valid_o); end
        checks++; if (bus.onehot_o !== 32'h80) begin errors++; $display("FAIL flush_onehot: got %h expected 80", bus.onehot_o); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 3) != 0), 5'($urandom), 2'($urandom),
                  1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) != 0));
            checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready[%0d]: got %b expected %b", n, obs_ready, exp_ready); end
            checks++; if (bus.out_valid_o !== m_valid) begin errors++; $display("FAIL rnd_valid[%0d]: got %b expected %b", n, bus.out_valid_o, m_valid); end
            checks++; if (bus.mask_o !== m_mask) begin errors++; $display("FAIL rnd_mask[%0d]: got %h expected %h", n, bus.mask_o, m_mask); end
            checks++; if (bus.onehot_o !== m_onehot) begin errors++; $display("FAIL rnd_onehot[%0d]: got %h expected %h", n, bus.onehot_o, m_onehot); end
            checks++; if (bus.count_o !== 6'(popcount(m_mask))) begin errors++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", n, bus.count_o, popcount(m_mask)); end
            checks++; if (bus.empty_o !== (m_mask == 0)) begin errors++; $display("FAIL rnd_empty[%0d]: got %b expected %b", n, bus.empty_o, m_mask == 0); end
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 5'd12, 2'd0, 1'b0, 1'b0);
        checks++; if (bus.out_valid_o !== 1'b1) begin errors++; $display("FAIL ar_pre_valid: got %b expected 1", bus.out_valid_o); end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b expected 0", bus.out_valid_o); end
        checks++; if (bus.mask_o !== 32'h0) begin errors++; $display("FAIL ar_mask: got %h expected 0", bus.mask_o); end
        checks++; if (bus.empty_o !== 1'b1) begin errors++; $display("FAIL ar_empty: got %b expected 1", bus.empty_o); end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 5'd0, 2'd0, 1'b0, 1'b0);
        checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL ar_ready: got %b expected 1", obs_ready); end
        checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL ar_post_valid: got %b expected 0", bus.out_valid_o); end
    endtask

    initial begin
        bus.in_valid_i = 1'b0; bus.idx_i = '0; bus.op_i = '0;
        bus.flush_i = 1'b0; bus.out_ready_i = 1'b0;
        model_reset();
        exp_ready = 1'b0; obs_ready = 1'b0;
        @(posedge clk);
        test_reset();
        test_load_msb();
        test_back_to_back();
        test_stall();
        test_clr_toggle();
        test_full_flush();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
